// File: rtl/hazard_stall_unit.sv
// ID-stage hazard/stall unit: load-use, load-to-branch and taken-branch flush control.
// Stall/bubble/flush outputs are Mealy; small FSM tracks flush length, stall runs and bubbles.
module hazard_stall_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MAX_STALL    = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic             ID_Branch,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_rd,
  input  logic             EXMEM_MemRead,
  input  logic [4:0]       EXMEM_rd,
  input  logic             Branch_taken,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             Mux_Write,
  output logic             IFID_Flush,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] bubble_count
);

  localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(MAX_STALL);
  localparam logic [RUN_W-1:0] RUN_PRE    = RUN_W'(MAX_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       flush_left_q, flush_left_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic             stall_timeout_q, stall_timeout_d;
  logic [CNT_W-1:0] bubble_count_q, bubble_count_d;

  logic lu_c;
  logic lb_c;
  logic haz_c;

  // Hazard detection; x0 never creates a dependency
  always_comb begin
    lu_c  = IDEX_MemRead && (IDEX_rd != 5'd0) &&
            ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));
    lb_c  = ID_Branch && EXMEM_MemRead && (EXMEM_rd != 5'd0) &&
            ((EXMEM_rd == IFID_rs1) || (EXMEM_rd == IFID_rs2));
    haz_c = lu_c || lb_c;
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_RUN;
      flush_left_q    <= 3'd0;
      run_len_q       <= '0;
      stall_timeout_q <= 1'b0;
      bubble_count_q  <= '0;
    end else begin
      state_q         <= state_d;
      flush_left_q    <= flush_left_d;
      run_len_q       <= run_len_d;
      stall_timeout_q <= stall_timeout_d;
      bubble_count_q  <= bubble_count_d;
    end
  end

  // Next-state: branch beats an ongoing flush, which beats a data hazard
  always_comb begin
    state_d         = state_q;
    flush_left_d    = flush_left_q;
    run_len_d       = run_len_q;
    stall_timeout_d = stall_timeout_q;
    bubble_count_d  = bubble_count_q;

    if (Branch_taken) begin
      run_len_d = '0;
      if (FLUSH_CYCLES > 1) begin
        state_d      = S_FLUSH;
        flush_left_d = FLUSH_INIT;
      end else begin
        state_d      = S_RUN;
        flush_left_d = 3'd0;
      end
    end else if (state_q == S_FLUSH) begin
      run_len_d = '0;
      if (flush_left_q <= 3'd1) begin
        state_d      = S_RUN;
        flush_left_d = 3'd0;
      end else begin
        flush_left_d = 3'(flush_left_q - 3'd1);
      end
    end else if (haz_c) begin
      state_d = S_STALL;
      if (run_len_q != RUN_MAX) begin
        run_len_d = RUN_W'(run_len_q + 1'b1);
      end
      if (run_len_q >= RUN_PRE) begin
        stall_timeout_d = 1'b1;
      end
    end else begin
      state_d   = S_RUN;
      run_len_d = '0;
    end

    if (!Mux_Write && (bubble_count_q != CNT_MAX)) begin
      bubble_count_d = CNT_W'(bubble_count_q + 1'b1);
    end
  end

  // Mealy control outputs, forced inactive while reset is held
  always_comb begin
    PCWrite    = 1'b0;
    IFID_Write = 1'b0;
    Mux_Write  = 1'b0;
    IFID_Flush = 1'b0;
    if (!reset) begin
      if (Branch_taken || (state_q == S_FLUSH)) begin
        PCWrite    = 1'b1;
        IFID_Write = 1'b1;
        IFID_Flush = 1'b1;
      end else if (!haz_c) begin
        PCWrite    = 1'b1;
        IFID_Write = 1'b1;
        Mux_Write  = 1'b1;
      end
    end
  end

  assign stall_timeout = stall_timeout_q;
  assign bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed literal checks plus randomized run against a behavioural model.
module tb_hazard_stall_unit;

  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned MAX_STALL    = 4;
  localparam int unsigned CNT_W        = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       IFID_rs1, IFID_rs2, IDEX_rd, EXMEM_rd;
  logic             ID_Branch, IDEX_MemRead, EXMEM_MemRead, Branch_taken;
  logic             PCWrite, IFID_Write, Mux_Write, IFID_Flush, stall_timeout;
  logic [CNT_W-1:0] bubble_count;

  always #5 clk = ~clk;

  hazard_stall_unit #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .MAX_STALL   (MAX_STALL),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .IFID_rs1     (IFID_rs1),
    .IFID_rs2     (IFID_rs2),
    .ID_Branch    (ID_Branch),
    .IDEX_MemRead (IDEX_MemRead),
    .IDEX_rd      (IDEX_rd),
    .EXMEM_MemRead(EXMEM_MemRead),
    .EXMEM_rd     (EXMEM_rd),
    .Branch_taken (Branch_taken),
    .PCWrite      (PCWrite),
    .IFID_Write   (IFID_Write),
    .Mux_Write    (Mux_Write),
    .IFID_Flush   (IFID_Flush),
    .stall_timeout(stall_timeout),
    .bubble_count (bubble_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hazard();
    bit lu, lb;
    lu = IDEX_MemRead && IDEX_rd != 0 && (IDEX_rd == IFID_rs1 || IDEX_rd == IFID_rs2);
    lb = ID_Branch && EXMEM_MemRead && EXMEM_rd != 0 &&
         (EXMEM_rd == IFID_rs1 || EXMEM_rd == IFID_rs2);
    return lu || lb;
  endfunction

  // Model: forced flush cycles still to come, current stall run, sticky timeout, bubbles
  int m_flush, m_run, m_bub;
  bit m_to, m_bubble_now;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_flush = 0; m_run = 0; m_bub = 0; m_to = 0;
    end else begin
      m_bubble_now = Branch_taken || m_flush > 0 || hazard();
      if (Branch_taken) begin
        m_flush = FLUSH_CYCLES - 1;
        m_run   = 0;
      end else if (m_flush > 0) begin
        m_flush--;
        m_run = 0;
      end else if (hazard()) begin
        m_run++;
        if (m_run >= MAX_STALL) m_to = 1;
      end else begin
        m_run = 0;
      end
      if (m_bubble_now && m_bub < (2**CNT_W) - 1) m_bub++;
    end
  end

  logic e_pc, e_ifid, e_mux, e_flush;

  // Compare DUT against model mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      {e_pc, e_ifid, e_mux, e_flush} = 4'b0000;
    end else if (Branch_taken || m_flush > 0) begin
      {e_pc, e_ifid, e_mux, e_flush} = 4'b1101;
    end else if (hazard()) begin
      {e_pc, e_ifid, e_mux, e_flush} = 4'b0000;
    end else begin
      {e_pc, e_ifid, e_mux, e_flush} = 4'b1110;
    end
    chk("PCWrite",       32'(PCWrite),       32'(e_pc));
    chk("IFID_Write",    32'(IFID_Write),    32'(e_ifid));
    chk("Mux_Write",     32'(Mux_Write),     32'(e_mux));
    chk("IFID_Flush",    32'(IFID_Flush),    32'(e_flush));
    chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
    chk("bubble_count",  32'(bubble_count),  32'(m_bub));
  end

  task automatic clr_in();
    IFID_rs1 = 5'd0; IFID_rs2 = 5'd0; IDEX_rd = 5'd0; EXMEM_rd = 5'd0;
    ID_Branch = 1'b0; IDEX_MemRead = 1'b0; EXMEM_MemRead = 1'b0; Branch_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_lu();
    IDEX_MemRead = 1'b1; IDEX_rd = 5'd5; IFID_rs1 = 5'd5;
  endtask

  task automatic rand_in(input bit allow_rst, input int unsigned bt_one_in);
    IFID_rs1      = 5'($urandom_range(0, 3));
    IFID_rs2      = 5'($urandom_range(0, 3));
    IDEX_rd       = 5'($urandom_range(0, 3));
    EXMEM_rd      = 5'($urandom_range(0, 3));
    ID_Branch     = 1'($urandom_range(0, 1));
    IDEX_MemRead  = 1'($urandom_range(0, 1));
    EXMEM_MemRead = 1'($urandom_range(0, 1));
    Branch_taken  = ($urandom_range(0, bt_one_in - 1) == 0);
    reset         = allow_rst && ($urandom_range(0, 63) == 0);
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    repeat (2) @(posedge clk);
    #2;
    // reset forces controls low regardless of inputs
    Branch_taken = 1'b1; set_lu();
    #1;
    chk("rst_pc",    32'(PCWrite),      0);
    chk("rst_ifid",  32'(IFID_Write),   0);
    chk("rst_mux",   32'(Mux_Write),    0);
    chk("rst_flush", 32'(IFID_Flush),   0);
    chk("rst_bub",   32'(bubble_count), 0);
    clr_in();
    reset = 1'b0;
    #1;
    chk("run_pc",  32'(PCWrite),   1);
    chk("run_mux", 32'(Mux_Write), 1);
    tick();

    // load-use stall
    set_lu();
    #1;
    chk("t1_pc",   32'(PCWrite),    0);
    chk("t1_ifid", 32'(IFID_Write), 0);
    chk("t1_mux",  32'(Mux_Write),  0);
    tick(); clr_in();
    chk("t1_bub", 32'(bubble_count), 1);

    // x0 destination never stalls
    IDEX_MemRead = 1'b1; IDEX_rd = 5'd0; IFID_rs1 = 5'd0;
    #1;
    chk("t2_pc",   32'(PCWrite),    1);
    chk("t2_ifid", 32'(IFID_Write), 1);
    chk("t2_mux",  32'(Mux_Write),  1);
    tick(); clr_in();
    chk("t2_bub", 32'(bubble_count), 1);

    // load-to-branch only when ID holds a branch
    ID_Branch = 1'b1; EXMEM_MemRead = 1'b1; EXMEM_rd = 5'd7; IFID_rs2 = 5'd7;
    #1;
    chk("t3_pc",  32'(PCWrite),   0);
    chk("t3_mux", 32'(Mux_Write), 0);
    tick();
    ID_Branch = 1'b0;
    #1;
    chk("t3_nb_pc",  32'(PCWrite),   1);
    chk("t3_nb_mux", 32'(Mux_Write), 1);
    tick(); clr_in();
    chk("t3_bub", 32'(bubble_count), 2);

    // taken branch: two flush cycles, hazard ignored in the second
    Branch_taken = 1'b1;
    #1;
    chk("t4a_flush", 32'(IFID_Flush), 1);
    chk("t4a_mux",   32'(Mux_Write),  0);
    chk("t4a_pc",    32'(PCWrite),    1);
    tick();
    Branch_taken = 1'b0; set_lu();
    #1;
    chk("t4b_flush", 32'(IFID_Flush), 1);
    chk("t4b_mux",   32'(Mux_Write),  0);
    chk("t4b_pc",    32'(PCWrite),    1);
    chk("t4b_ifid",  32'(IFID_Write), 1);
    tick(); clr_in();
    #1;
    chk("t4c_flush", 32'(IFID_Flush), 0);
    chk("t4c_mux",   32'(Mux_Write),  1);
    chk("t4_bub",    32'(bubble_count), 4);

    // stall run reaches MAX_STALL on the fourth edge
    set_lu();
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("t5_to_%0d", k), 32'(stall_timeout), 32'(k == 4));
    end
    clr_in();
    tick();
    chk("t5_sticky", 32'(stall_timeout), 1);
    chk("t5_bub",    32'(bubble_count), 8);

    // reset in the middle of a flush
    Branch_taken = 1'b1;
    tick();
    Branch_taken = 1'b0;
    chk("t6_bub9", 32'(bubble_count), 9);
    #1;
    chk("t6_midflush", 32'(IFID_Flush), 1);
    reset = 1'b1;
    #1;
    chk("t6_pc",    32'(PCWrite),       0);
    chk("t6_flush", 32'(IFID_Flush),    0);
    chk("t6_mux",   32'(Mux_Write),     0);
    chk("t6_bub",   32'(bubble_count),  0);
    chk("t6_to",    32'(stall_timeout), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_rel_mux",   32'(Mux_Write),  1);
    chk("t6_rel_pc",    32'(PCWrite),    1);
    chk("t6_rel_flush", 32'(IFID_Flush), 0);
    tick();

    // randomized traffic with occasional resets, then a reset-free stretch to saturate
    for (int i = 0; i < 1200; i++) begin
      rand_in(1'b1, 10);
      tick();
    end
    for (int i = 0; i < 400; i++) begin
      rand_in(1'b0, 6);
      tick();
    end
    reset = 1'b0;
    clr_in();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
